alu_mul_seq: RTL

Multi-cycle shift-add multiplier sequencer that drives the datapath ALU's operand and control inputs and consumes its result and flags (q, mayor, zero, paridad).
It time-multiplexes the single ALU over the operations suma, shift_i, shift_d and pasar_b to compute an N x N product.
The result is the low N bits plus an overflow flag.
It sits between the instruction/control logic (start/done handshake) and the existing alu instance.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 43 ++++
 rtl/alu_mul_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the datapath ALU and the shift-add multiplier sequencer.
// The opcode and state encodings are fixed because other blocks decode them directly.
package alu_pkg;

    typedef logic [2:0] alu_op_t;
    typedef logic [2:0] seq_state_t;

    localparam alu_op_t SUMA    = 3'b000;
    localparam alu_op_t SHIFT_D = 3'b001;
    localparam alu_op_t RESTA   = 3'b010;
    localparam alu_op_t SHIFT_I = 3'b011;
    localparam alu_op_t PASAR_B = 3'b100;

    localparam seq_state_t IDLE = 3'd0;
    localparam seq_state_t TEST = 3'd1;
    localparam seq_state_t ADD  = 3'd2;
    localparam seq_state_t SHL  = 3'd3;
    localparam seq_state_t SHR  = 3'd4;
    localparam seq_state_t DONE = 3'd5;

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU: add, subtract, single-bit shifts and pass-through.
// 'mayor' is the carry-out for suma and a > b for resta.
module alu
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   ctrl,
    output logic [N-1:0] q,
    output logic         mayor,
    output logic         zero,
    output logic         paridad
);

    logic [N:0] sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};

    always_comb begin
        q     = '0;
        mayor = 1'b0;
        case (ctrl)
            SUMA: begin
                q     = sum_ext[N-1:0];
                mayor = sum_ext[N];
            end
            RESTA: begin
                q     = a - b;
                mayor = (a > b);
            end
            SHIFT_D: q = a >> 1;
            SHIFT_I: q = a << 1;
            PASAR_B: q = b;
            default: q = '0;
        endcase
    end

    assign zero    = (q == '0);
    assign paridad = q[N-1];

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the shared ALU one operation per cycle.
// Produces the low N bits of M*R plus a sticky overflow flag.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_product,
    output logic         o_overflow,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [2:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_q,
    input  logic         i_alu_mayor,
    input  logic         i_alu_zero,
    input  logic         i_alu_paridad
);

    seq_state_t   state_reg, state_next;
    logic [N-1:0] m_reg, m_next;
    logic [N-1:0] r_reg, r_next;
    logic [N-1:0] acc_reg, acc_next;
    logic         ovf_reg, ovf_next;
    logic         msb_out_reg, msb_out_next;
    logic [N-1:0] product_reg, product_next;
    logic         overflow_reg, overflow_next;

    logic         unused_paridad;
    assign unused_paridad = i_alu_paridad;

    always_comb begin
        state_next    = state_reg;
        m_next        = m_reg;
        r_next        = r_reg;
        acc_next      = acc_reg;
        ovf_next      = ovf_reg;
        msb_out_next  = msb_out_reg;
        product_next  = product_reg;
        overflow_next = overflow_reg;
        o_alu_a       = '0;
        o_alu_b       = '0;
        o_alu_ctrl    = SUMA;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    m_next     = i_multiplicand;
                    r_next     = i_multiplier;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = TEST;
                end
            end
            TEST: begin
                o_alu_ctrl = PASAR_B;
                o_alu_b    = r_reg;
                if (i_alu_zero)
                    state_next = DONE;
                else if (r_reg[0])
                    state_next = ADD;
                else
                    state_next = SHL;
            end
            ADD: begin
                o_alu_ctrl = SUMA;
                o_alu_a    = acc_reg;
                o_alu_b    = m_reg;
                acc_next   = i_alu_q;
                ovf_next   = ovf_reg | i_alu_mayor;
                state_next = SHL;
            end
            SHL: begin
                o_alu_ctrl   = SHIFT_I;
                o_alu_a      = m_reg;
                m_next       = i_alu_q;
                msb_out_next = m_reg[N-1];
                state_next   = SHR;
            end
            SHR: begin
                o_alu_ctrl = SHIFT_D;
                o_alu_a    = r_reg;
                r_next     = i_alu_q;
                // A bit lost off the top of M only matters if more multiplier bits follow.
                if (i_alu_zero) begin
                    state_next = DONE;
                end else begin
                    ovf_next   = ovf_reg | msb_out_reg;
                    state_next = i_alu_q[0] ? ADD : SHL;
                end
            end
            DONE: begin
                product_next  = acc_reg;
                overflow_next = ovf_reg;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            m_reg        <= '0;
            r_reg        <= '0;
            acc_reg      <= '0;
            ovf_reg      <= 1'b0;
            msb_out_reg  <= 1'b0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            m_reg        <= m_next;
            r_reg        <= r_next;
            acc_reg      <= acc_next;
            ovf_reg      <= ovf_next;
            msb_out_reg  <= msb_out_next;
            product_reg  <= product_next;
            overflow_reg <= overflow_next;
        end
    end

    assign o_busy     = (state_reg != IDLE);
    assign o_done     = (state_reg == DONE);
    assign o_product  = product_reg;
    assign o_overflow = overflow_reg;

endmodule
